// File: rtl/kf_step_seq_pkg.sv
// Shared definitions for the Kalman step sequencer: stage indices,
// state encodings and small decode helpers used by the top level.
package kf_step_seq_pkg;

    // Number of stage blocks driven by the sequencer
    localparam int KF_NSTG = 5;

    // Stage indices into st_start / st_done
    localparam int KF_ST_PX   = 0;  // predict state vector
    localparam int KF_ST_PP   = 1;  // predict covariance
    localparam int KF_ST_EST  = 2;  // estimated output
    localparam int KF_ST_GAIN = 3;  // Kalman gain
    localparam int KF_ST_UPD  = 4;  // state / covariance update

    // State encodings; IDLE is zero so a cleared register reads as IDLE
    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_PRED      = 4'd1;
    localparam logic [3:0] S_PRED_WAIT = 4'd2;
    localparam logic [3:0] S_MEAS      = 4'd3;
    localparam logic [3:0] S_CORR      = 4'd4;
    localparam logic [3:0] S_CORR_WAIT = 4'd5;
    localparam logic [3:0] S_UPD       = 4'd6;
    localparam logic [3:0] S_UPD_WAIT  = 4'd7;
    localparam logic [3:0] S_DONE      = 4'd8;

    typedef logic [KF_NSTG-1:0] stage_vec_t;

    // Launch pulses owned by each one-cycle issue state
    function automatic stage_vec_t stage_starts(input logic [3:0] st);
        stage_vec_t v;
        v = '0;
        case (st)
            S_PRED: begin
                v[KF_ST_PX] = 1'b1;
                v[KF_ST_PP] = 1'b1;
            end
            S_CORR: begin
                v[KF_ST_EST]  = 1'b1;
                v[KF_ST_GAIN] = 1'b1;
            end
            S_UPD:   v[KF_ST_UPD] = 1'b1;
            default: v = '0;
        endcase
        return v;
    endfunction

    // States in which the sequencer waits on an external event
    function automatic logic is_wait(input logic [3:0] st);
        return (st == S_PRED_WAIT) || (st == S_MEAS) ||
               (st == S_CORR_WAIT) || (st == S_UPD_WAIT);
    endfunction

endpackage

// File: rtl/kf_step_seq_join2.sv
// kf_join2: two-input done latch. While enabled it remembers which of the
// two stage dones has been seen; all_done rises as soon as both have been
// seen, counting a done arriving in the current cycle. A held done level
// simply keeps its bit set, so it counts once. The latch is emptied by clr.
module kf_join2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic [1:0] done_in,
    output logic       all_done
);

    logic [1:0] seen;

    // Accumulate dones while enabled; forget them on clear or reset
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            seen <= 2'b00;
        end else if (en) begin
            seen <= seen | done_in;
        end
    end

    assign all_done = en & (&(seen | done_in));

endmodule

// File: rtl/kf_step_seq.sv
// kf_step_seq: sequencer for one fixed-point Kalman iteration.
// Launches predict-x/predict-P, waits for a measurement, launches
// est-output/gain, then update, and reports completion. Owns no arithmetic.
//
// Optional watchdog: define KF_SEQ_WDOG_EN to bound every wait state to
// WDOG_CYC cycles; expiry forces DONE with err=1. Without the macro err is 0
// and the wait states wait indefinitely.
//
// Measurement handshake: meas_ready is high exactly while the sequencer sits
// in MEAS; a measurement is accepted on a rising clock edge where both
// meas_valid and meas_ready are high, and meas_valid may be raised before
// meas_ready (it is then accepted on the first MEAS cycle).
module kf_step_seq
    import kf_step_seq_pkg::*;
#(
    parameter int ITER_W   = 16,
    parameter int WDOG_CYC = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               predict_only,
    input  logic               meas_valid,
    output logic               meas_ready,
    output logic [KF_NSTG-1:0] st_start,
    input  logic [KF_NSTG-1:0] st_done,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [3:0]         state_o,
    output logic [ITER_W-1:0]  iter_cnt
);

    logic [3:0] state;
    logic [3:0] state_nxt;
    logic       po_q;
    logic       pred_en;
    logic       corr_en;
    logic       pred_all;
    logic       corr_all;
    logic       abort;
    logic       finish_ok;

    assign pred_en = (state == S_PRED_WAIT);
    assign corr_en = (state == S_CORR_WAIT);

    // Join of predict-x and predict-P completions
    kf_join2 u_pred_join (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (~pred_en),
        .en       (pred_en),
        .done_in  (st_done[KF_ST_PP:KF_ST_PX]),
        .all_done (pred_all)
    );

    // Join of est-output and gain completions
    kf_join2 u_corr_join (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (~corr_en),
        .en       (corr_en),
        .done_in  (st_done[KF_ST_GAIN:KF_ST_EST]),
        .all_done (corr_all)
    );

    // Next-state logic; a watchdog abort overrides any normal transition
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (start) state_nxt = S_PRED;
            S_PRED:      state_nxt = S_PRED_WAIT;
            S_PRED_WAIT: if (pred_all) state_nxt = po_q ? S_DONE : S_MEAS;
            S_MEAS:      if (meas_valid) state_nxt = S_CORR;
            S_CORR:      state_nxt = S_CORR_WAIT;
            S_CORR_WAIT: if (corr_all) state_nxt = S_UPD;
            S_UPD:       state_nxt = S_UPD_WAIT;
            S_UPD_WAIT:  if (st_done[KF_ST_UPD]) state_nxt = S_DONE;
            S_DONE:      state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
        if (abort) begin
            state_nxt = S_DONE;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Capture the predict-only mode together with an accepted start
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            po_q <= 1'b0;
        end else if (state == S_IDLE && start) begin
            po_q <= predict_only;
        end
    end

    // An iteration counts only when it reaches DONE without an abort
    assign finish_ok = (state != S_DONE) && (state_nxt == S_DONE) && !abort;

    // Completed-iteration counter, wraps naturally at 2^ITER_W
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            iter_cnt <= '0;
        end else if (finish_ok) begin
            iter_cnt <= iter_cnt + ITER_W'(1);
        end
    end

`ifdef KF_SEQ_WDOG_EN
    localparam int WD_W = $clog2(WDOG_CYC + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            err_q;

    // Cycles spent in the current wait state; restarts on every state change
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wd_cnt <= '0;
        end else if (state_nxt != state) begin
            wd_cnt <= '0;
        end else if (is_wait(state) && wd_cnt != WD_W'(WDOG_CYC)) begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end
    end

    assign abort = is_wait(state) && (wd_cnt == WD_W'(WDOG_CYC));

    // Abort flag: set with the forced DONE, held until the next start
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (state == S_IDLE && start) begin
            err_q <= 1'b0;
        end else if (abort) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign abort = 1'b0;
    assign err   = 1'b0;
`endif

    assign st_start   = stage_starts(state);
    assign meas_ready = (state == S_MEAS);
    assign busy       = (state != S_IDLE) && (state != S_DONE);
    assign done       = (state == S_DONE);
    assign state_o    = state;

endmodule
